// File: rtl/lease_tracker_nway.sv
// lease_tracker_nway
// Lease-state tracker for an N-way set-associative lease cache. It keeps one
// lease counter per line. Each reference decays the other leases in the
// addressed set by one. On a miss it picks the fill way: the lowest expired
// way if there is one, otherwise a pseudo-random way (a forced eviction).
// A request passes through three states, IDLE -> UPDATE -> DONE, so a new
// request can start every three cycles.
module lease_tracker_nway #(
  parameter int CACHE_BLOCK_CAPACITY = 128,
  parameter int NUM_WAYS             = 8,
  parameter int BW_LEASE             = 16,
  localparam int NUM_SETS            = CACHE_BLOCK_CAPACITY / NUM_WAYS,
  localparam int BW_SET              = $clog2(NUM_SETS),
  localparam int BW_WAY              = $clog2(NUM_WAYS)
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                req_i,
  input  logic [BW_SET-1:0]   req_set_i,
  input  logic                req_hit_i,
  input  logic [BW_WAY-1:0]   req_way_i,
  input  logic [BW_LEASE-1:0] lease_i,
  output logic                ready_o,
  output logic                done_o,
  output logic [BW_WAY-1:0]   victim_way_o,
  output logic                expired_o,
  output logic                forced_o,
  output logic                bypass_o,
  input  logic [BW_SET-1:0]   dbg_set_i,
  input  logic [BW_WAY-1:0]   dbg_way_i,
  output logic [BW_LEASE-1:0] dbg_lease_o
);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting).
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;

  // Latched request
  logic [BW_SET-1:0]   set_q;
  logic                hit_q;
  logic [BW_WAY-1:0]   way_q;
  logic [BW_LEASE-1:0] req_lease_q;

  // Lease storage, one counter per line
  logic [BW_LEASE-1:0] lease_mem_q [NUM_SETS][NUM_WAYS];

  // Free-running replacement LFSR
  logic [15:0]         lfsr_q, lfsr_d;

  // Registered result
  logic [BW_WAY-1:0]   victim_q;
  logic                expired_q, forced_q, bypass_q;

  // Target selection for the latched set
  logic                zero_found;
  logic [BW_WAY-1:0]   zero_way;
  logic                tgt_valid;
  logic [BW_WAY-1:0]   tgt_way;
  logic                expired_d, forced_d, bypass_d;
  logic [BW_LEASE-1:0] set_next [NUM_WAYS];

  // State register
  // NOTE: all clocked state uses non-blocking assignments, so every register
  // samples the values from before the edge and the order of these blocks
  // does not matter.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs
  // NOTE: every signal driven from an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (req_i) begin
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Capture the request when it is accepted in IDLE
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      set_q       <= '0;
      hit_q       <= 1'b0;
      way_q       <= '0;
      req_lease_q <= '0;
    end else if (state_q == ST_IDLE && req_i) begin
      set_q       <= req_set_i;
      hit_q       <= req_hit_i;
      way_q       <= req_way_i;
      req_lease_q <= lease_i;
    end
  end

  // The LFSR steps every cycle, also while a request is in flight
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
  end

  // LFSR register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Find the lowest-index expired way in the latched set. The scan runs from
  // the top down so that the last match, which is the lowest index, wins.
  always_comb begin
    zero_found = 1'b0;
    zero_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (lease_mem_q[set_q][w] == '0) begin
        zero_found = 1'b1;
        zero_way   = BW_WAY'(w);
      end
    end
  end

  // Choose the target way and the result flags from the leases before decay
  always_comb begin
    tgt_valid = 1'b0;
    tgt_way   = '0;
    expired_d = 1'b0;
    forced_d  = 1'b0;
    bypass_d  = 1'b0;
    if (hit_q) begin
      tgt_valid = 1'b1;
      tgt_way   = way_q;
    end else if (req_lease_q != '0) begin
      tgt_valid = 1'b1;
      if (zero_found) begin
        tgt_way   = zero_way;
        expired_d = 1'b1;
      end else begin
        tgt_way  = lfsr_q[BW_WAY-1:0];
        forced_d = 1'b1;
      end
    end else begin
      bypass_d = 1'b1;
    end
  end

  // New leases for the latched set: the target takes the new lease and every
  // other way decays by exactly one, stopping at zero
  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      set_next[w] = lease_mem_q[set_q][w];
      if (tgt_valid && tgt_way == BW_WAY'(w)) begin
        set_next[w] = req_lease_q;
      end else if (lease_mem_q[set_q][w] != '0) begin
        set_next[w] = lease_mem_q[set_q][w] - 1'b1;
      end
    end
  end

  // Lease storage: all writes to one set are committed in UPDATE. A reset in
  // the same cycle wins, so the write is dropped.
  // NOTE: the lease array is reset as well, because lease 0 is what marks a
  // line as invalid. A cache that powered up with stale leases would keep
  // lines it never filled.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          lease_mem_q[s][w] <= '0;
        end
      end
    end else if (state_q == ST_UPDATE) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        lease_mem_q[set_q][w] <= set_next[w];
      end
    end
  end

  // Result registers: loaded in UPDATE and held until the next UPDATE
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      victim_q  <= '0;
      expired_q <= 1'b0;
      forced_q  <= 1'b0;
      bypass_q  <= 1'b0;
    end else if (state_q == ST_UPDATE) begin
      victim_q  <= tgt_valid ? tgt_way : '0;
      expired_q <= expired_d;
      forced_q  <= forced_d;
      bypass_q  <= bypass_d;
    end
  end

  assign victim_way_o = victim_q;
  assign expired_o    = expired_q;
  assign forced_o     = forced_q;
  assign bypass_o     = bypass_q;
  assign dbg_lease_o  = lease_mem_q[dbg_set_i][dbg_way_i];

  // The miss outcome flags are mutually exclusive
  a_flags_onehot0 : assert property (
    @(posedge clock_i) disable iff (reset_i)
      $onehot0({expired_q, forced_q, bypass_q}));

  // A bypass never reports a victim way
  a_bypass_victim : assert property (
    @(posedge clock_i) disable iff (reset_i)
      bypass_q |-> (victim_q == '0));

endmodule

// File: tb/tb_lease_tracker_nway.sv
// Bench for lease_tracker_nway. It drives directed and random references and
// compares the results against a scoreboard fed by a set/way lease model.
module tb_lease_tracker_nway;

  localparam int CAP = 128;
  localparam int NW  = 8;
  localparam int BWL = 16;
  localparam int NS  = CAP / NW;
  localparam int BWS = $clog2(NS);
  localparam int BWW = $clog2(NW);

  logic           clk;
  logic           reset_i;
  logic           req_i;
  logic [BWS-1:0] req_set_i;
  logic           req_hit_i;
  logic [BWW-1:0] req_way_i;
  logic [BWL-1:0] lease_i;
  logic           ready_o;
  logic           done_o;
  logic [BWW-1:0] victim_way_o;
  logic           expired_o;
  logic           forced_o;
  logic           bypass_o;
  logic [BWS-1:0] dbg_set_i;
  logic [BWW-1:0] dbg_way_i;
  logic [BWL-1:0] dbg_lease_o;

  lease_tracker_nway #(
    .CACHE_BLOCK_CAPACITY(CAP),
    .NUM_WAYS(NW),
    .BW_LEASE(BWL)
  ) dut (
    .clock_i(clk),
    .reset_i(reset_i),
    .req_i(req_i),
    .req_set_i(req_set_i),
    .req_hit_i(req_hit_i),
    .req_way_i(req_way_i),
    .lease_i(lease_i),
    .ready_o(ready_o),
    .done_o(done_o),
    .victim_way_o(victim_way_o),
    .expired_o(expired_o),
    .forced_o(forced_o),
    .bypass_o(bypass_o),
    .dbg_set_i(dbg_set_i),
    .dbg_way_i(dbg_way_i),
    .dbg_lease_o(dbg_lease_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int victim;
    int expired;
    int forced;
    int bypass;
    int cyc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          m_lease[NS][NW];
  logic [15:0] m_lfsr = 16'hACE1;

  // Reference LFSR and cycle counter, stepped at every rising edge
  always @(posedge clk) begin
    cyc++;
    if (reset_i) m_lfsr = 16'hACE1;
    else         m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done_o pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done_o === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("victim_way", victim_way_o, e.victim);
        check("expired", expired_o, e.expired);
        check("forced", forced_o, e.forced);
        check("bypass", bypass_o, e.bypass);
      end
    end
  end

  // Reference model of one reference. It uses the leases from before the
  // reference and the LFSR value of the cycle in which the tracker updates.
  task automatic model_ref(input int s, input bit hit, input int way,
                           input int lease, output exp_t e);
    int tgt;
    tgt = -1;
    e.victim = 0; e.expired = 0; e.forced = 0; e.bypass = 0; e.cyc = 0;
    if (hit) begin
      tgt = way;
    end else if (lease != 0) begin
      for (int w = 0; w < NW; w++) begin
        if (tgt < 0 && m_lease[s][w] == 0) tgt = w;
      end
      if (tgt >= 0) e.expired = 1;
      else begin
        tgt = int'(m_lfsr) % NW;
        e.forced = 1;
      end
    end else begin
      e.bypass = 1;
    end
    if (tgt >= 0) e.victim = tgt;
    for (int w = 0; w < NW; w++) begin
      if (w == tgt)             m_lease[s][w] = lease;
      else if (m_lease[s][w] > 0) m_lease[s][w] = m_lease[s][w] - 1;
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", 0, 1);
  endtask

  // Present one request, hold it until it is accepted, then queue its result.
  // Returns at the UPDATE cycle.
  task automatic issue(input int s, input bit hit, input int way,
                       input int lease, output exp_t e);
    wait_ready();
    req_i     = 1'b1;
    req_set_i = BWS'(s);
    req_hit_i = hit;
    req_way_i = BWW'(way);
    lease_i   = BWL'(lease);
    @(posedge clk);
    #1;
    req_i = 1'b0;
    model_ref(s, hit, way, lease, e);
    e.cyc = cyc + 1;
    sbq.push_back(e);
  endtask

  task automatic req(input int s, input bit hit, input int way, input int lease);
    exp_t e;
    issue(s, hit, way, lease, e);
  endtask

  // Read one lease back and compare it with the model
  task automatic chk_dbg(input int s, input int w);
    @(negedge clk);
    dbg_set_i = BWS'(s);
    dbg_way_i = BWW'(w);
    #1;
    check($sformatf("dbg_lease[%0d][%0d]", s, w), dbg_lease_o, m_lease[s][w]);
  endtask

  // Read one lease back and compare it with a fixed value
  task automatic chk_dbg_const(input int s, input int w, input int v);
    @(negedge clk);
    dbg_set_i = BWS'(s);
    dbg_way_i = BWW'(w);
    #1;
    check($sformatf("dbg_const[%0d][%0d]", s, w), dbg_lease_o, v);
  endtask

  task automatic chk_all();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) chk_dbg(s, w);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) m_lease[s][w] = 0;
    reset_i = 1'b1; req_i = 1'b0; req_set_i = '0; req_hit_i = 1'b0;
    req_way_i = '0; lease_i = '0; dbg_set_i = '0; dbg_way_i = '0;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;

    // Reset state
    check("rst_ready", ready_o, 1);
    check("rst_done", done_o, 0);
    check("rst_victim", victim_way_o, 0);
    check("rst_expired", expired_o, 0);
    check("rst_forced", forced_o, 0);
    check("rst_bypass", bypass_o, 0);
    chk_dbg_const(3, 1, 0);

    // Two misses to set 3 fill ways 0 and 1
    req(3, 0, 0, 5);
    req(3, 0, 0, 7);
    wait_ready();
    chk_dbg_const(3, 0, 4);
    chk_dbg_const(3, 1, 7);

    // A hit on way 0 refreshes it and decays way 1. Set 2 is untouched.
    req(3, 1, 0, 10);
    wait_ready();
    chk_dbg_const(3, 0, 10);
    chk_dbg_const(3, 1, 6);
    chk_dbg_const(2, 0, 0);

    // Fill set 5 so that no way is expired, then force an eviction
    for (int i = 0; i < NW; i++) req(5, 0, 0, 100);
    issue(5, 0, 0, 9, e);
    check("forced_flag_model", e.forced, 1);
    wait_ready();
    chk_dbg_const(5, e.victim, 9);
    chk_dbg(5, (e.victim + 1) % NW);

    // Set 1: way0 decays from 1 to 0 and is the next fill target
    req(1, 0, 0, 2);
    req(1, 0, 0, 50);
    req(1, 0, 0, 20);
    wait_ready();
    chk_dbg_const(1, 0, 0);
    chk_dbg_const(1, 2, 20);
    req(1, 0, 0, 30);
    wait_ready();
    chk_dbg_const(1, 0, 30);

    // Set 4: a miss with zero lease bypasses, and way0 still decays
    req(4, 0, 0, 4);
    req(4, 1, 0, 3);
    req(4, 0, 0, 0);
    wait_ready();
    chk_dbg_const(4, 0, 2);
    chk_dbg_const(4, 1, 0);

    // Reset during UPDATE: the write is dropped, no done, all leases clear
    wait_ready();
    req_i = 1'b1; req_set_i = BWS'(6); req_hit_i = 1'b0; req_way_i = '0;
    lease_i = BWL'(11);
    @(posedge clk);
    #1;
    req_i = 1'b0;
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) m_lease[s][w] = 0;
    check("post_rst_ready", ready_o, 1);
    check("post_rst_done", done_o, 0);
    repeat (4) @(negedge clk);
    chk_all();

    // A request held during DONE is ignored and produces no second done
    req(6, 0, 0, 13);
    @(posedge clk);
    #1;
    req_i = 1'b1; req_set_i = BWS'(6); req_hit_i = 1'b0; lease_i = BWL'(40);
    @(posedge clk);
    #1;
    req_i = 1'b0;
    check("done_drop_ready", ready_o, 1);
    repeat (4) @(negedge clk);
    chk_dbg_const(6, 0, 13);
    chk_dbg_const(6, 1, 0);

    // Random references concentrated on a few sets, with idle gaps
    for (int i = 0; i < 300; i++) begin
      int s, way, lease;
      bit hit;
      s     = $urandom_range(0, 3);
      hit   = ($urandom_range(0, 2) == 0);
      way   = $urandom_range(0, NW - 1);
      lease = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12);
      if ($urandom_range(0, 15) == 0) lease = $urandom_range(1000, 65535);
      req(s, hit, way, lease);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_ready();
    chk_all();

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lease_tracker_nway.md
# lease_tracker_nway

Parametrised lease-state tracker for the N-way set-associative lease cache. It holds one lease counter per cache line and decays the leases of the addressed set on every reference. It picks the fill way on a miss: the first expired line, otherwise a pseudo-random line flagged as a forced eviction. It sits beside the tag memory in the lease cache controller and generalises the fixed 8-way replacement logic to any power-of-two associativity.

## Interface
Parameters:
- CACHE_BLOCK_CAPACITY, 128, total cache lines; power of two, ≥ 2·NUM_WAYS
- NUM_WAYS, 8, associativity; power of two, 2..16
- BW_LEASE, 16, lease counter width
- Derived: NUM_SETS = CACHE_BLOCK_CAPACITY/NUM_WAYS, BW_SET = clog2(NUM_SETS), BW_WAY = clog2(NUM_WAYS)

Ports (one clock; reset is synchronous and active-high):
- clock_i  in  1  controller clock
- reset_i  in  1  synchronous active-high reset
- req_i  in  1  request strobe, sampled only when ready_o=1
- req_set_i  in  BW_SET  set index of the reference
- req_hit_i  in  1  1: tag hit, 0: miss
- req_way_i  in  BW_WAY  hit way (ignored on a miss)
- lease_i  in  BW_LEASE  lease assigned to the referenced line
- ready_o  out  1  idle, can accept a request
- done_o  out  1  one-cycle pulse, result valid
- victim_way_o  out  BW_WAY  way written (hit way or fill way)
- expired_o  out  1  miss filled into an expired line
- forced_o  out  1  miss evicted an unexpired line (random choice)
- bypass_o  out  1  miss with zero lease, no line allocated
- dbg_set_i  in  BW_SET  debug readback set
- dbg_way_i  in  BW_WAY  debug readback way
- dbg_lease_o  out  BW_LEASE  combinational lease of [dbg_set_i][dbg_way_i]

## Operation
- Storage: NUM_SETS×NUM_WAYS registers of BW_LEASE bits. Lease 0 means the line is expired or invalid.
- FSM states: IDLE → UPDATE → DONE → IDLE.
  - IDLE: ready_o=1. On req_i=1, latch set, hit, way and lease, then go to UPDATE.
  - UPDATE: select the target way and commit all lease writes for the latched set in this single cycle. Register the result outputs. Go to DONE.
  - DONE: done_o=1 with the result outputs. Go to IDLE.
- Target selection in UPDATE, using pre-decay leases:
  - Hit: target = latched way. expired_o=0, forced_o=0.
  - Miss with lease_i≠0: target = lowest-index way with lease 0, and expired_o=1. If no way has lease 0, target = lfsr[BW_WAY-1:0] and forced_o=1.
  - Miss with lease_i=0: no target, bypass_o=1, victim_way_o=0.
- Lease update in UPDATE:
  - Target way ← lease_i. On a hit with lease_i=0, the line expires immediately.
  - Every other way in the set: lease ← lease−1 if nonzero, otherwise stays 0 (saturating). Decrement is exactly 1 per reference, regardless of lease value.
  - Other sets are untouched.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset. It advances every clock cycle, including while busy.
- req_i while ready_o=0 is ignored; there is no queueing. The requester must hold or re-present the request.

## Timing
- Request accepted at clock edge t (IDLE with req_i=1). Leases are written at edge t+1. done_o is high during cycle t+2. ready_o returns in cycle t+3. Throughput is one request per 3 cycles.
- victim_way_o, expired_o, forced_o and bypass_o are registered. They are valid only while done_o=1 and hold their value until the next UPDATE.
- dbg_lease_o reflects writes from the cycle after edge t+1.
- Reset values: state IDLE, ready_o=1, done_o=0, victim_way_o=0, expired_o=0, forced_o=0, bypass_o=0, all leases 0, lfsr=16'hACE1.
- Reset asserted in UPDATE or DONE:
  - Any write from UPDATE is discarded, because reset has priority at the same edge.
  - done_o is suppressed.
  - ready_o=1 in the first cycle after reset deasserts.
- Simultaneous events: a request and reset at the same edge means reset wins and the request is dropped.
- At most one of expired_o, forced_o, bypass_o is high. All three are 0 on a hit.

## Test plan
- Reset, then miss set 3 lease 5 → done_o 2 cycles after acceptance, victim_way_o=0, expired_o=1. Then miss set 3 lease 7 → victim_way_o=1; dbg reads set3/way0=4, set3/way1=7.
- Hit set 3 way 0 lease 10 → victim_way_o=0, flags 0; way0=10, way1=6; set 2 leases unchanged (0).
- Fill all 8 ways of set 5 with lease 100, then miss set 5 lease 9 → forced_o=1, victim_way_o equals the reference LFSR[2:0] at the UPDATE cycle, and that way=9.
- Set 1: way0 lease 1, way1 lease 50; miss lease 20 decays way0 to 0 → next miss set 1 selects way0, expired_o=1.
- Miss set 4 lease 0 with way0=3 → bypass_o=1, no allocation, way0=2.
- Reset pulsed during UPDATE → no done_o, all dbg leases 0, ready_o=1 next cycle. A req_i pulse during DONE is ignored, with no second done_o.
